// File: rtl/landing_gear_controller.sv
// Landing-gear sequencer: Moore FSM driving gear hydraulics, cockpit LEDs and
// the takeoff timer from gear/ground sensors, timer expiry and the pilot lever.
module landing_gear_controller (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       GearIsDown,
    input  logic       GearIsUp,
    input  logic       PlaneOnGround,
    input  logic       TimeUp,
    input  logic       Lever,
    output logic       RedLED,
    output logic       GrnLED,
    output logic       Valve,
    output logic       Pump,
    output logic       Timer,
    output logic [2:0] State,
    output logic [2:0] NextState
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OUT_W   = 5;

    typedef enum logic [STATE_W-1:0] {
        TAXI  = 3'd0,
        TUP   = 3'd1,
        TDN   = 3'd2,
        GOUP  = 3'd3,
        GODN  = 3'd4,
        FLYUP = 3'd5,
        FLYDN = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [OUT_W-1:0]   out_q;
    logic [OUT_W-1:0]   out_d;

    // Output decode {RedLED,GrnLED,Valve,Pump,Timer}; illegal code looks like TAXI
    function automatic logic [OUT_W-1:0] decode(input state_t s);
        logic [OUT_W-1:0] o;
        o = 5'b01000;
        case (s)
            TAXI:    o = 5'b01000;
            TUP:     o = 5'b01001;
            TDN:     o = 5'b01001;
            GOUP:    o = 5'b10110;
            GODN:    o = 5'b10010;
            FLYUP:   o = 5'b00100;
            FLYDN:   o = 5'b01000;
            default: o = 5'b01000;
        endcase
        return o;
    endfunction

    // Next-state logic; lever reversal beats sensor/timer, ground beats lever
    always_comb begin
        state_d = state_q;
        case (state_q)
            TAXI: begin
                if (PlaneOnGround)  state_d = TAXI;
                else if (!Lever)    state_d = TUP;
                else                state_d = TDN;
            end
            TUP: begin
                if (PlaneOnGround)  state_d = TAXI;
                else if (Lever)     state_d = TDN;
                else if (TimeUp)    state_d = GOUP;
            end
            TDN: begin
                if (PlaneOnGround)  state_d = TAXI;
                else if (!Lever)    state_d = TUP;
                else if (TimeUp)    state_d = FLYDN;
            end
            GOUP: begin
                if (Lever)          state_d = GODN;
                else if (GearIsUp)  state_d = FLYUP;
            end
            FLYUP: begin
                if (Lever)          state_d = GODN;
            end
            GODN: begin
                if (!Lever)         state_d = GOUP;
                else if (GearIsDown) state_d = FLYDN;
            end
            FLYDN: begin
                if (PlaneOnGround)  state_d = TAXI;
                else if (!Lever)    state_d = GOUP;
            end
            default:                state_d = TAXI;
        endcase
    end

    // Outputs follow the state they will accompany, so they register alongside it
    assign out_d = decode(state_d);

    // State and output registers; reset lands in TAXI with its outputs
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= TAXI;
            out_q   <= 5'b01000;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign State     = STATE_W'(state_q);
    assign NextState = STATE_W'(state_d);
    assign {RedLED, GrnLED, Valve, Pump, Timer} = out_q;

endmodule

// File: tb/tb_landing_gear_controller.sv
// Directed bench for landing_gear_controller with hand-computed expectations.
module tb_landing_gear_controller;

    logic       Clock = 1'b0;
    logic       Clear;
    logic       GearIsDown, GearIsUp, PlaneOnGround, TimeUp, Lever;
    logic       RedLED, GrnLED, Valve, Pump, Timer;
    logic [2:0] State, NextState;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] S_TAXI = 3'd0, S_TUP = 3'd1, S_TDN = 3'd2, S_GOUP = 3'd3,
                           S_GODN = 3'd4, S_FLYUP = 3'd5, S_FLYDN = 3'd6;

    landing_gear_controller dut (
        .Clock(Clock), .Clear(Clear),
        .GearIsDown(GearIsDown), .GearIsUp(GearIsUp),
        .PlaneOnGround(PlaneOnGround), .TimeUp(TimeUp), .Lever(Lever),
        .RedLED(RedLED), .GrnLED(GrnLED), .Valve(Valve), .Pump(Pump), .Timer(Timer),
        .State(State), .NextState(NextState)
    );

    always #5 Clock = ~Clock;

    // Single comparison point for every check
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected {Red,Grn,Valve,Pump,Timer} per state, straight from the output table
    function automatic logic [4:0] exp_out(input logic [2:0] s);
        case (s)
            S_TUP, S_TDN: return 5'b01001;
            S_GOUP:       return 5'b10110;
            S_GODN:       return 5'b10010;
            S_FLYUP:      return 5'b00100;
            default:      return 5'b01000;
        endcase
    endfunction

    function automatic logic [4:0] outs();
        return {RedLED, GrnLED, Valve, Pump, Timer};
    endfunction

    // Drive {Down,Up,Ground,TimeUp,Lever} at negedge, check NextState, then state/outputs after the edge
    task automatic step(input string tag, input logic [4:0] vec, input logic [2:0] exp_s);
        @(negedge Clock);
        {GearIsDown, GearIsUp, PlaneOnGround, TimeUp, Lever} = vec;
        #1;
        check({tag, ".next"}, 8'(NextState), 8'(exp_s));
        @(posedge Clock);
        #1;
        check({tag, ".state"}, 8'(State), 8'(exp_s));
        check({tag, ".outs"}, 8'(outs()), 8'(exp_out(exp_s)));
    endtask

    initial begin
        Clear = 1'b0;
        {GearIsDown, GearIsUp, PlaneOnGround, TimeUp, Lever} = 5'b00000;

        // Reset held with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            {GearIsDown, GearIsUp, PlaneOnGround, TimeUp, Lever} = 5'($urandom);
            @(posedge Clock);
            #1;
            check("rst.state", 8'(State), 8'(S_TAXI));
            check("rst.outs", 8'(outs()), 8'(5'b01000));
        end
        @(negedge Clock);
        {GearIsDown, GearIsUp, PlaneOnGround, TimeUp, Lever} = 5'b10100;
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        check("rel.state", 8'(State), 8'(S_TAXI));

        // Nominal flight cycle
        step("nom0", 5'b10100, S_TAXI);
        step("nom1", 5'b10000, S_TUP);
        step("nom2", 5'b00010, S_GOUP);
        step("nom3", 5'b01010, S_FLYUP);
        step("nom4", 5'b01011, S_GODN);
        step("nom5", 5'b10111, S_FLYDN);
        step("nom6", 5'b10100, S_TAXI);

        // Aborted takeoff
        step("abt0", 5'b00001, S_TDN);
        step("abt1", 5'b00011, S_FLYDN);
        step("abt2", 5'b00000, S_GOUP);

        // Lever reversal outranks sensor
        step("rev0", 5'b01001, S_GODN);
        step("rev1", 5'b00000, S_GOUP);
        step("hold_goup", 5'b10000, S_GOUP);
        step("rev2", 5'b00001, S_GODN);
        step("hold_godn", 5'b01001, S_GODN);
        step("rev3", 5'b10001, S_FLYDN);
        step("hold_flydn", 5'b00001, S_FLYDN);

        // Touch-and-go and ground priority
        step("tg0", 5'b00101, S_TAXI);
        step("tg1", 5'b00000, S_TUP);
        step("hold_tup", 5'b10000, S_TUP);
        step("tg2", 5'b00110, S_TAXI);
        step("tup_tdn0", 5'b00000, S_TUP);
        step("tup_tdn1", 5'b00001, S_TDN);
        step("hold_tdn", 5'b00001, S_TDN);
        step("tdn_tup", 5'b00010, S_TUP);
        step("tup_tdn2", 5'b00011, S_TDN);
        step("tdn_gnd", 5'b00111, S_TAXI);

        // FLYUP ignores ground and sensors until lever goes down
        step("fu0", 5'b00000, S_TUP);
        step("fu1", 5'b00010, S_GOUP);
        step("fu2", 5'b01000, S_FLYUP);
        step("fu_hold", 5'b10110, S_FLYUP);
        step("fu3", 5'b00101, S_GODN);
        step("fu4", 5'b00000, S_GOUP);

        // Async reset mid-transit: drops to TAXI before the next edge
        @(negedge Clock);
        #2;
        Clear = 1'b0;
        #1;
        check("arst.state", 8'(State), 8'(S_TAXI));
        check("arst.pump", 8'(Pump), 8'(1'b0));
        check("arst.outs", 8'(outs()), 8'(5'b01000));
        @(negedge Clock);
        {GearIsDown, GearIsUp, PlaneOnGround, TimeUp, Lever} = 5'b00100;
        Clear = 1'b1;
        step("post_arst", 5'b00000, S_TUP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
